// File: rtl/stopwatch_core.sv
// mm:ss stopwatch core: synchronizes the divided clock levels, turns them into one-cycle
// ticks, and runs a RUN/PAUSED FSM with normal counting and per-field adjust.
module stopwatch_core (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  input  logic       clk_adjust,
  input  logic       pause_pulse,
  input  logic       adjust,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSED = 1'b1} state_e;

  typedef struct packed {
    logic       carry;
    logic [3:0] tens;
    logic [3:0] ones;
  } field_t;

  // Modulo-60 BCD increment; out-of-range digits fold back to 0 so the field self-heals.
  function automatic field_t bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
    field_t r;
    r.carry = 1'b0;
    r.tens  = tens;
    r.ones  = ones + 4'd1;
    if (ones >= 4'd9) begin
      r.ones = 4'd0;
      if (tens >= 4'd5) begin
        r.tens  = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.tens = tens + 4'd1;
      end
    end
    return r;
  endfunction

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] synca_q, synca_d;
  logic       prev1_q, prev1_d;
  logic       prev2_q, prev2_d;
  state_e     state_q, state_d;
  logic       running_q, running_d;
  logic       blank_min_q, blank_min_d;
  logic       blank_sec_q, blank_sec_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;

  logic   tick1, tick2;
  field_t sec_inc, min_inc;

  assign tick1 = sync1_q[1] & ~prev1_q;
  assign tick2 = sync2_q[1] & ~prev2_q;

  assign sec_inc = bcd60_inc(sec_tens_q, sec_ones_q);
  assign min_inc = bcd60_inc(min_tens_q, min_ones_q);

  always_comb begin
    sync1_d = {sync1_q[0], clk_1Hz};
    sync2_d = {sync2_q[0], clk_2Hz};
    synca_d = {synca_q[0], clk_adjust};
    prev1_d = sync1_q[1];
    prev2_d = sync2_q[1];

    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;

    // Increment is decided by state_q, so a coincident pause_pulse cannot suppress it.
    if (adjust) begin
      if (tick2) begin
        if (sel) begin
          sec_tens_d = sec_inc.tens;
          sec_ones_d = sec_inc.ones;
        end else begin
          min_tens_d = min_inc.tens;
          min_ones_d = min_inc.ones;
        end
      end
    end else if (tick1 && (state_q == ST_RUN)) begin
      sec_tens_d = sec_inc.tens;
      sec_ones_d = sec_inc.ones;
      if (sec_inc.carry) begin
        min_tens_d = min_inc.tens;
        min_ones_d = min_inc.ones;
      end
    end

    state_d = state_q;
    if (pause_pulse) state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    running_d = (state_d == ST_RUN);

    blank_min_d = adjust & ~sel & synca_q[1];
    blank_sec_d = adjust &  sel & synca_q[1];
  end

  // NOTE: synchronizer and previous-sample flops reset to 1 so an input already high at
  // reset release does not look like a rising edge; only state uses non-blocking updates.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      synca_q     <= 2'b11;
      prev1_q     <= 1'b1;
      prev2_q     <= 1'b1;
      state_q     <= ST_RUN;
      running_q   <= 1'b1;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      synca_q     <= synca_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      state_q     <= state_d;
      running_q   <= running_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
  assign running   = running_q;

endmodule
